// File: rtl/sprite_mover_if.sv
// Control/status bundle between game logic and the sprite mover:
// joystick, mode and load inputs, plus position, tick and hit outputs.
interface sprite_mover_if #(
  parameter int H_W    = 12,
  parameter int V_W    = 11,
  parameter int AXIS_W = 4
);
  logic              enable;
  logic [1:0]        mode;
  logic [AXIS_W-1:0] x_axis;
  logic [AXIS_W-1:0] y_axis;
  logic              load;
  logic [H_W-1:0]    load_h;
  logic [V_W-1:0]    load_v;
  logic [H_W-1:0]    hor_pos;
  logic [V_W-1:0]    ver_pos;
  logic              tick;
  logic              hit_h;
  logic              hit_v;

  modport master (
    output enable, mode, x_axis, y_axis, load, load_h, load_v,
    input  hor_pos, ver_pos, tick, hit_h, hit_v
  );

  modport slave (
    input  enable, mode, x_axis, y_axis, load, load_h, load_v,
    output hor_pos, ver_pos, tick, hit_h, hit_v
  );
endinterface

// File: rtl/sprite_mover.sv
// Joystick-driven sprite position generator: periodic motion tick, run-time
// selectable wrap/bounce/clamp edge handling, position load and edge-hit strobes.
module sprite_mover #(
  parameter int HOR_FIELD   = 799,
  parameter int VER_FIELD   = 599,
  parameter int SIZE        = 25,
  parameter int H_W         = 12,
  parameter int V_W         = 11,
  parameter int AXIS_W      = 4,
  parameter int X_CENTER    = 7,
  parameter int Y_CENTER    = 8,
  parameter int DEADZONE    = 0,
  parameter int TICK_PERIOD = 524289,
  parameter int START_H     = 1,
  parameter int START_V     = 1
) (
  input logic           clock,
  input logic           reset,
  sprite_mover_if.slave bus
);
  localparam int CNT_W = $clog2(TICK_PERIOD);
  // One bit wider than the raw axis difference so negating the most negative value is safe.
  localparam int OW    = AXIS_W + 2;
  localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_PERIOD - 1);
  localparam logic signed [OW-1:0] DZ        = OW'(DEADZONE);
  localparam logic signed [H_W+1:0] H_MIN = (H_W+2)'(1);
  localparam logic signed [H_W+1:0] H_MAX = (H_W+2)'(HOR_FIELD - SIZE);
  localparam logic signed [V_W+1:0] V_MIN = (V_W+2)'(1);
  localparam logic signed [V_W+1:0] V_MAX = (V_W+2)'(VER_FIELD - SIZE);

  typedef enum logic [1:0] {WRAP = 2'd0, BOUNCE = 2'd1, CLAMP = 2'd2, CLAMP_ALT = 2'd3} mode_e;

  logic [CNT_W-1:0]  cnt;
  logic              tick_q, hit_h_q, hit_v_q, flip_x, flip_y;
  logic [H_W-1:0]    hor_q, h_next;
  logic [V_W-1:0]    ver_q, v_next;
  logic signed [OW-1:0]    dx, dy;
  logic signed [H_W+1:0]   nh;
  logic signed [V_W+1:0]   nv;
  logic              h_lo, h_hi, v_lo, v_hi;
  mode_e             mode;

  assign mode = mode_e'(bus.mode);

  // Signed a-b, zeroed inside the deadzone, optionally reversed for bounce.
  function automatic logic signed [OW-1:0] offset(input logic [AXIS_W-1:0] a,
                                                  input logic [AXIS_W-1:0] b,
                                                  input logic neg);
    logic signed [OW-1:0] d, m;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    m = d[OW-1] ? -d : d;
    if (m <= DZ) return '0;
    return neg ? -d : d;
  endfunction

  always_comb begin
    dx   = offset(bus.x_axis, AXIS_W'(X_CENTER), (mode == BOUNCE) && flip_x);
    dy   = offset(AXIS_W'(Y_CENTER), bus.y_axis, (mode == BOUNCE) && flip_y);
    nh   = $signed({2'b00, hor_q}) + $signed({{(H_W+2-OW){dx[OW-1]}}, dx});
    nv   = $signed({2'b00, ver_q}) + $signed({{(V_W+2-OW){dy[OW-1]}}, dy});
    h_lo = nh < H_MIN;
    h_hi = nh > H_MAX;
    v_lo = nv < V_MIN;
    v_hi = nv > V_MAX;
    if (mode == WRAP) begin
      h_next = h_lo ? H_MAX[H_W-1:0] : (h_hi ? H_MIN[H_W-1:0] : nh[H_W-1:0]);
      v_next = v_lo ? V_MAX[V_W-1:0] : (v_hi ? V_MIN[V_W-1:0] : nv[V_W-1:0]);
    end else begin
      h_next = h_lo ? H_MIN[H_W-1:0] : (h_hi ? H_MAX[H_W-1:0] : nh[H_W-1:0]);
      v_next = v_lo ? V_MIN[V_W-1:0] : (v_hi ? V_MAX[V_W-1:0] : nv[V_W-1:0]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      tick_q  <= 1'b0;
      hor_q   <= H_W'(START_H);
      ver_q   <= V_W'(START_V);
      hit_h_q <= 1'b0;
      hit_v_q <= 1'b0;
      flip_x  <= 1'b0;
      flip_y  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.enable) begin
        if (cnt == TICK_LAST) begin
          cnt    <= '0;
          tick_q <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      hit_h_q <= 1'b0;
      hit_v_q <= 1'b0;
      if (mode != BOUNCE) begin
        flip_x <= 1'b0;
        flip_y <= 1'b0;
      end
      // Load wins over a coincident tick; the motion is dropped, not deferred.
      if (bus.load) begin
        hor_q  <= bus.load_h;
        ver_q  <= bus.load_v;
        flip_x <= 1'b0;
        flip_y <= 1'b0;
      end else if (tick_q) begin
        hor_q   <= h_next;
        ver_q   <= v_next;
        hit_h_q <= h_lo | h_hi;
        hit_v_q <= v_lo | v_hi;
        if (mode == BOUNCE) begin
          flip_x <= flip_x ^ (h_lo | h_hi);
          flip_y <= flip_y ^ (v_lo | v_hi);
        end
      end
    end
  end

  assign bus.hor_pos = hor_q;
  assign bus.ver_pos = ver_q;
  assign bus.tick    = tick_q;
  assign bus.hit_h   = hit_h_q;
  assign bus.hit_v   = hit_v_q;
endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover with a short tick period and deadzone of 1:
// vector table for edge modes, plus hand sequences for tick timing, load/tick and reset.
module tb_sprite_mover;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  sprite_mover_if #(.H_W(12), .V_W(11), .AXIS_W(4)) bif ();

  sprite_mover #(.DEADZONE(1), .TICK_PERIOD(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         do_load;
    logic [1:0] mode;
    logic [3:0] x, y;
    int         lh, lv;
    int         eh, ev;
    bit         hh, hv;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns 1 ns after the edge on which tick goes high.
  task automatic wait_tick();
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      step();
      got = bif.tick;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL tick_timeout: got no tick expected tick within 12 cycles");
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    if (v.do_load) begin
      wait_tick();
      step();
      bif.mode   = v.mode;
      bif.x_axis = v.x;
      bif.y_axis = v.y;
      bif.load_h = 12'(v.lh);
      bif.load_v = 11'(v.lv);
      bif.load   = 1'b1;
      step();
      bif.load   = 1'b0;
    end else begin
      bif.mode   = v.mode;
      bif.x_axis = v.x;
      bif.y_axis = v.y;
    end
    wait_tick();
    step();
    chk($sformatf("v%0d_hor", idx), int'(bif.hor_pos), v.eh);
    chk($sformatf("v%0d_ver", idx), int'(bif.ver_pos), v.ev);
    chk($sformatf("v%0d_hit_h", idx), int'(bif.hit_h), int'(v.hh));
    chk($sformatf("v%0d_hit_v", idx), int'(bif.hit_v), int'(v.hv));
  endtask

  initial begin
    // MAX_H = 774, MAX_V = 574, dx = x-7, dy = 8-y, deadzone |d|<=1
    vecs[0]  = '{1'b1, 2'd0,  2,  8,   3, 300, 774, 300, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd0, 15,  8, 770, 300,   1, 300, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 10,  5, 100, 100, 103, 103, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'd0,  4, 11,   0,   0, 100, 100, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'd0,  7, 14, 100,   3, 100, 574, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 2'd0, 15,  0, 774, 574,   1,   1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 2'd1,  7,  0, 100, 572, 100, 574, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 2'd1,  7,  0,   0,   0, 100, 566, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd2,  8,  9, 400, 300, 400, 300, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd2,  6,  7,   0,   0, 400, 300, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd2,  9,  8,   0,   0, 402, 300, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 15,  8, 770, 300, 774, 300, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 15,  8,   0,   0, 774, 300, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 2'd3,  9,  6, 772, 572, 774, 574, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 2'd2,  5, 10,   3,   3,   1,   1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 2'd1,  0,  8,   5, 300,   1, 300, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 2'd1,  0,  8,   0,   0,   8, 300, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 2'd2,  0,  8,   0,   0,   1, 300, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 2'd1,  0,  8,   0,   0,   1, 300, 1'b1, 1'b0};

    bif.enable = 1'b1;
    bif.mode   = 2'd0;
    bif.x_axis = 4'd7;
    bif.y_axis = 4'd8;
    bif.load   = 1'b0;
    bif.load_h = '0;
    bif.load_v = '0;

    // Reset values, then tick cadence from reset release.
    repeat (3) step();
    chk("rst_hor", int'(bif.hor_pos), 1);
    chk("rst_ver", int'(bif.ver_pos), 1);
    chk("rst_tick", int'(bif.tick), 0);
    chk("rst_hits", int'({bif.hit_h, bif.hit_v}), 0);
    reset = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk($sformatf("tick_c%0d", c), int'(bif.tick), int'(c % 4 == 0));
    end
    bif.enable = 1'b0;
    for (int c = 13; c <= 19; c++) begin
      if (c == 16) bif.enable = 1'b1;
      step();
      chk($sformatf("tick_en_c%0d", c), int'(bif.tick), int'(c == 19));
    end

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Hit strobe lasts a single cycle.
    step();
    chk("hit_one_shot", int'(bif.hit_h), 0);

    // Load on the tick edge wins and clears flip_x (set by vector 18).
    wait_tick();
    bif.load_h = 12'd100;
    bif.load_v = 11'd200;
    bif.load   = 1'b1;
    step();
    bif.load   = 1'b0;
    chk("ldtick_hor", int'(bif.hor_pos), 100);
    chk("ldtick_ver", int'(bif.ver_pos), 200);
    chk("ldtick_hits", int'({bif.hit_h, bif.hit_v}), 0);
    wait_tick();
    step();
    chk("ldtick_flip_clr", int'(bif.hor_pos), 93);

    // Reset in the middle of a bounce with flip_x set.
    bif.load_h = 12'd5;
    bif.load_v = 11'd300;
    bif.load   = 1'b1;
    step();
    bif.load   = 1'b0;
    wait_tick();
    step();
    chk("rb_bounce_hor", int'(bif.hor_pos), 1);
    wait_tick();
    step();
    chk("rb_flipped_hor", int'(bif.hor_pos), 8);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rb_hor", int'(bif.hor_pos), 1);
    chk("rb_ver", int'(bif.ver_pos), 1);
    chk("rb_tick", int'(bif.tick), 0);
    chk("rb_hits", int'({bif.hit_h, bif.hit_v}), 0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("rb_tick_c%0d", c), int'(bif.tick), int'(c == 4));
    end
    step();
    chk("rb_noflip_hor", int'(bif.hor_pos), 1);
    chk("rb_noflip_hit", int'(bif.hit_h), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
